muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
//  Sits beside the EX-stage ALU. Accepts MULT/MULTU/DIV/DIVU from EX and runs a radix-2 shift-add or
//  restoring-divide loop, one bit per cycle. Raises busy so the hazard unit stalls MFHI/MFLO/MTHI/MTLO
//  and any new mul/div until the result is committed. MTHI/MTLO write the registers directly when idle.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width in bits; must be >= 4. Iteration counter width is clog2(WIDTH+1) (localparam).
// PORTS
//  Clk      in   1      rising-edge clock
//  Reset    in   1      asynchronous, active-low reset
//  start    in   1      launch an operation using op/a/b (sampled only when busy==0)
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a        in   WIDTH  multiplicand / dividend (rs)
//  b        in   WIDTH  multiplier / divisor (rt)
//  mthi     in   1      write wdata to HI (idle only)
//  mtlo     in   1      write wdata to LO (idle only)
//  wdata    in   WIDTH  data for MTHI/MTLO
//  busy     out  1      operation in flight; pipeline stalls on HI/LO access
//  done     out  1      one-cycle pulse: HI/LO now hold the new result
//  dz       out  1      valid with done: the division had divisor 0
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
// BEHAVIOUR
//  Reset (Reset==0, async): state=IDLE, hi=lo=0, busy=done=dz=0, counter=0. Reset mid-operation aborts it.
//  FSM IDLE -> CALC -> FIX -> IDLE.
//   IDLE: start=1 latches |a|,|b| (magnitudes for signed ops; raw values for unsigned), op, the sign of a,
//     and the sign of a XOR the sign of b. It then goes to CALC with counter=WIDTH.
//   CALC: one bit per cycle for exactly WIDTH cycles; counter decrements and the state leaves CALC at 0.
//     Mul: shift-add into a 2*WIDTH accumulator.
//     Div: restoring division (shift in, trial subtract, set quotient bit).
//   FIX: one cycle. The final HI/LO values are written at the end of this cycle. Signed corrections:
//     - MULT: negate the 2*WIDTH product if the operand signs differ.
//     - DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
//  Latency: start sampled in cycle 0; busy=1 in cycles 1..WIDTH+1. In cycle WIDTH+2, busy=0, done=1,
//   and hi/lo carry the result.
//  Result mapping:
//   - mul: {hi,lo} = product.
//   - div: lo = quotient, hi = remainder.
//  Divide by zero (b==0): the loop still runs for uniform latency. The forced result is lo={WIDTH{1}},
//   hi=a (raw), with no sign fix, and dz=1 alongside done. dz=0 on every other done.
//  Signed overflow (-2^(WIDTH-1) / -1): lo=0x80..0 (wrapped pattern), hi=0, dz=0.
//  start while busy: ignored. There is no queue; the hazard unit must hold the instruction.
//  mthi/mtlo while busy: ignored.
//  mthi/mtlo in IDLE: the register updates on the next edge.
//  start and mthi/mtlo in the same IDLE cycle: start wins; the MT write is dropped.
//  done is high for exactly one cycle. A start in that done cycle is accepted, so the next op begins
//   back to back.
//  hi/lo hold their old values throughout CALC and FIX; there are no partial results on the outputs.
// STRUCTURE
//  Shared package muldiv_pkg:
//   - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
//   - state encodings S_IDLE/S_CALC/S_FIX
//  Sub-module muldiv_negate: combinational, parametrised two's-complement conditional negate
//   (en ? -x : x). It is instanced for operand magnitudes and for the FIX correction.
//  All state and datapath registers live in muldiv_unit.
// TESTING (WIDTH=32; done expected in cycle 34 after start in cycle 0)
//  1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy in cycles 1..33; done at 34.
//  2. MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  3. DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU 7/2 -> lo=3, hi=1.
//     DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5, dz=1 with done.
//     The next DIVU 6/3 -> dz=0, lo=2.
//  5. Idle mthi wdata=0x1234 -> hi=0x1234 next cycle.
//     During busy: pulse start and mtlo -> ignored; lo ends as the first op's result.
//     start+mthi in the same idle cycle -> mthi dropped.
//  6. Reset pulled low in cycle 10 of a MULT -> busy=0, hi=lo=0 immediately.
//     After release, MULTU 3*4 -> lo=12, done at 34.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
// No logic here; imported by muldiv_unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FIX    = 2'd2;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate (en ? -x : x).
// Purely combinational, zero latency, no flow control.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic             en,
    output logic [WIDTH-1:0] y
);

    assign y = en ? -x : x;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 MULT/MULTU/DIV/DIVU unit with HI/LO; done pulses WIDTH+2 cycles after start.
// start and mthi/mtlo are ignored while busy; the hazard unit must hold the instruction.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d;
    logic               sx_q, sx_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               op_signed, op_is_mul, q_is_div;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign op_signed = (op != OP_MULTU) && (op != OP_DIVU);
    assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign q_is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (.x(a), .en(op_signed & a[WIDTH-1]), .y(a_mag));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (.x(b), .en(op_signed & b[WIDTH-1]), .y(b_mag));

    // acc holds {partial product high, multiplier} or {remainder, dividend->quotient}.
    logic [WIDTH:0]     mul_add, mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next;

    assign mul_add   = acc_q[0] ? {1'b0, m_q} : '0;
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + mul_add;
    assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial = div_shift - {1'b0, m_q};
    assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               div_zero;

    // With a zero divisor every trial succeeds, so the remainder ends as |a| and
    // the dividend-sign fix below turns it back into the raw a.
    muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .x(acc_q), .en(sx_q & (op_q == OP_MULT)), .y(prod_fix));
    muldiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .x(acc_q[WIDTH-1:0]), .en(sx_q & (op_q == OP_DIV)), .y(quo_fix));
    muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .x(acc_q[2*WIDTH-1:WIDTH]), .en(sa_q & (op_q == OP_DIV)), .y(rem_fix));

    assign div_zero = q_is_div && (m_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sx_d    = sx_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    sa_d    = a[WIDTH-1];
                    sx_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    m_d     = op_is_mul ? a_mag : b_mag;
                    acc_d   = {{WIDTH{1'b0}}, (op_is_mul ? b_mag : a_mag)};
                    cnt_d   = CW'(WIDTH);
                    state_d = S_CALC;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_CALC: begin
                acc_d = q_is_div ? div_next : mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (q_is_div) begin
                    hi_d = rem_fix;
                    lo_d = div_zero ? '1 : quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                dz_d    = div_zero;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sx_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sx_q    <= sx_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases with literal results plus random traffic
// compared every cycle against an arithmetic model of HI/LO, busy, done and dz.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, from plain integer arithmetic.
    function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sp;
        logic [63:0] up;
        z = 1'b0;
        h = '0;
        l = '0;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                {h, l} = sp;
            end
            2'b01: begin
                up = {32'b0, x} * {32'b0, y};
                {h, l} = up;
            end
            default: begin
                if (y == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = x;
                    z = 1'b1;
                end else if (o == 2'b10) begin
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                        l = 32'h8000_0000;
                        h = 32'h0;
                    end else begin
                        l = $signed(x) / $signed(y);
                        h = $signed(x) % $signed(y);
                    end
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
    endfunction

    // Model: an accepted start makes the unit busy for W+1 cycles, then results appear with done.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    int          m_rem = 0;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0; m_rem = 0;
        end else begin
            m_done = 1'b0;
            m_dz   = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dz = p_dz;
                end
            end else if (start) begin
                ref_op(op, a, b, p_hi, p_lo, p_dz);
                m_rem = W + 1;
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
            end
        end
    end

    always @(negedge Clk) begin
        if (Reset) begin
            chk("cmp_busy", busy, m_rem > 0);
            chk("cmp_done", done, m_done);
            chk("cmp_dz", dz, m_dz);
            chk("cmp_hi", hi, m_hi);
            chk("cmp_lo", lo, m_lo);
        end
    end

    // Called just after a negedge; returns at the negedge where done is seen.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] eh, input logic [31:0] el,
                          input logic ez, input bit inj, input bit mth);
        int n;
        start = 1'b1; op = o; a = aa; b = bb; mthi = mth; wdata = 32'hDEAD_BEEF;
        for (n = 1; n <= 40; n++) begin
            @(negedge Clk);
            if (n == 1) begin
                start = 1'b0; mthi = 1'b0;
                chk({nm, "_busy1"}, busy, 1'b1);
            end
            if (n == 33) chk({nm, "_busy33"}, busy, 1'b1);
            if (inj && n == 5) begin
                start = 1'b1; op = 2'b01; a = 32'h11; b = 32'h22;
                mtlo = 1'b1; wdata = 32'h5555_5555;
            end
            if (inj && n == 6) begin
                start = 1'b0; mtlo = 1'b0;
            end
            if (done) break;
        end
        chk({nm, "_cycle"}, n, 34);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        chk({nm, "_dz"}, dz, ez);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 7));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dz", dz, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0, 0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
        run_op("divu_7_2", 2'b11, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0, 0, 0);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0, 0);
        run_op("divu_dz", 2'b11, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_op("divu_6_3", 2'b11, 32'h6, 32'h3, 32'h0, 32'h2, 1'b0, 0, 0);
        run_op("div_dz_neg", 2'b10, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0, 0);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 0, 0);

        mthi = 1'b1; wdata = 32'h1234;
        @(negedge Clk);
        mthi = 1'b0;
        chk("mthi_idle", hi, 32'h1234);
        mtlo = 1'b1; wdata = 32'hABCD;
        @(negedge Clk);
        mtlo = 1'b0;
        chk("mtlo_idle", lo, 32'hABCD);
        chk("mtlo_keep_hi", hi, 32'h1234);

        run_op("busy_inj", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0, 1, 0);
        run_op("start_mthi", 2'b01, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0, 0, 1);

        start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFD; b = 32'h5;
        for (int n = 1; n <= 10; n++) begin
            @(negedge Clk);
            start = 1'b0;
        end
        #2 Reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        run_op("after_rst", 2'b01, 32'h3, 32'h4, 32'h0, 32'hC, 1'b0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            start = ($urandom_range(0, 5) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = pick();
            b     = pick();
            mthi  = ($urandom_range(0, 4) == 0);
            mtlo  = ($urandom_range(0, 4) == 0);
            wdata = $urandom;
        end
        @(negedge Clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        repeat (40) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
